// File: rtl/decoder_rr_arbiter.sv
// Round-robin sequencer sharing one 2-to-4 one-hot decoder among four requesters.
// Drives decoder select (a, b) and enable (c). Every grant is registered and bounded by HOLD_MAX.
// The enable drops for one cycle between owners, so the decoder output breaks before it makes.

module decoder_rr_arbiter_chk (
  input logic       i_clk,
  input logic       i_rst,
  input logic       i_sel_a,
  input logic       i_sel_b,
  input logic       i_en,
  input logic [1:0] i_gnt_id,
  input logic [3:0] i_gnt,
  input logic       i_timeout
);

  a_gnt_onehot0: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(i_gnt));

  a_gnt_matches_decoder: assert property (@(posedge i_clk) disable iff (i_rst)
    i_gnt == (i_en ? (4'b0001 << {i_sel_a, i_sel_b}) : 4'b0000));

  a_sel_matches_id: assert property (@(posedge i_clk) disable iff (i_rst)
    {i_sel_a, i_sel_b} == i_gnt_id);

  a_timeout_only_in_gap: assert property (@(posedge i_clk) disable iff (i_rst)
    i_timeout |-> !i_en);

  a_no_owner_change_while_enabled: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_en && $past(i_en)) |-> (i_gnt_id == $past(i_gnt_id)));

endmodule

module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic       o_sel_a,
  output logic       o_sel_b,
  output logic       o_en,
  output logic [1:0] o_gnt_id,
  output logic [3:0] o_gnt,
  output logic       o_timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Bit 2 flags a valid pick.
  // Lower offsets from ptr overwrite higher ones, so the closest requester wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_gnt_id, w_gnt_id_nxt;
  logic       r_en, w_en_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic       r_timeout, w_timeout_nxt;

  logic [2:0] w_pick;
  logic       w_rel_done;
  logic       w_rel_drop;
  logic       w_rel_hold;

  assign w_pick     = rr_pick(i_req, r_ptr);
  assign w_rel_done = i_done;
  assign w_rel_drop = ~i_req[r_gnt_id];
  assign w_rel_hold = (r_cnt == HOLD_LAST);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_en_nxt      = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_pick[2]) begin
          w_state_nxt  = ST_GRANT;
          w_gnt_id_nxt = w_pick[1:0];
          w_en_nxt     = 1'b1;
          w_cnt_nxt    = 8'd0;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_rel_done || w_rel_drop || w_rel_hold) begin
          // A done or a dropped request takes precedence over the hold limit.
          // In that case no timeout is reported.
          w_state_nxt   = ST_GAP;
          w_ptr_nxt     = r_gnt_id + 2'd1;
          w_cnt_nxt     = 8'd0;
          w_timeout_nxt = w_rel_hold & ~w_rel_done & ~w_rel_drop;
        end else begin
          w_en_nxt  = 1'b1;
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
    if (w_en_nxt) begin
      w_gnt_nxt = 4'b0001 << w_gnt_id_nxt;
    end else begin
      w_gnt_nxt = 4'b0000;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_cnt     <= 8'd0;
      r_gnt_id  <= 2'd0;
      r_en      <= 1'b0;
      r_gnt     <= 4'b0000;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_en      <= w_en_nxt;
      r_gnt     <= w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign o_sel_a   = r_gnt_id[1];
  assign o_sel_b   = r_gnt_id[0];
  assign o_en      = r_en;
  assign o_gnt_id  = r_gnt_id;
  assign o_gnt     = r_gnt;
  assign o_timeout = r_timeout;

  decoder_rr_arbiter_chk u_chk (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_sel_a   (o_sel_a),
    .i_sel_b   (o_sel_b),
    .i_en      (o_en),
    .i_gnt_id  (o_gnt_id),
    .i_gnt     (o_gnt),
    .i_timeout (o_timeout)
  );

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares the 2-to-4 one-hot decoder among four requesters. It drives the decoder's select pair and enable (a, b, c), so exactly one decoder output (p, q, r, s) is active per grant. Grants are registered and bounded by a hold timeout. The enable drops for exactly one cycle between consecutive grants (break-before-make).

Parameters:
HOLD_MAX, 4, maximum consecutive cycles one grant may be held; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; synchronous to clk, active-high
req  input  4  request lines; req[i] requests decoder output i (0=p, 1=q, 2=r, 3=s)
done  input  1  current owner releases the grant; sampled only in GRANT
sel_a  output  1  decoder input a = gnt_id[1]
sel_b  output  1  decoder input b = gnt_id[0]
en  output  1  decoder input c (enable); high only in GRANT
gnt_id  output  2  index of the current or last owner
gnt  output  4  one-hot mirror of the decoder output (1<<gnt_id when en=1, else 0)
timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX

Behaviour:
- All outputs registered. Synchronous active-high reset forces: state=IDLE, ptr=0, gnt_id=0, sel_a=0, sel_b=0, en=0, gnt=0, timeout=0, cnt=0.
- Internal state: FSM {IDLE, GRANT, GAP}; 2-bit priority pointer ptr; 8-bit hold counter cnt.
- Arbitration function: winner = first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4, wrap 3->0) with req[i]=1.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise, next cycle: GRANT, gnt_id=winner, en=1, cnt=0.
  - Latency from req sampled high to en high: 1 cycle.
- GRANT (en=1): release when any of the following holds:
  - done=1
  - req[gnt_id]=0
  - cnt==HOLD_MAX-1. If this is the only release cause, pulse timeout for the following cycle.
  - If none holds, cnt increments.
  - A grant therefore lasts at most HOLD_MAX cycles. With HOLD_MAX=1, every grant lasts exactly 1 cycle.
- On release:
  - next state GAP, en=0, gnt=0.
  - ptr = gnt_id+1 mod 4.
  - gnt_id, sel_a and sel_b hold their last value.
- GAP (en=0 for exactly one cycle): run arbitration with the updated ptr.
  - Any req: next cycle GRANT as from IDLE.
  - Otherwise: IDLE.
  - The gap between two back-to-back grants is therefore exactly one cycle.
- Simultaneous events:
  - done together with timeout: treated as done release; timeout stays 0.
  - Multiple requests: only the round-robin winner is granted. Losers wait, with no starvation (ptr always advances past the last owner).
  - Requester that releases and re-requests immediately gets lowest priority on the next arbitration.
- done is ignored in IDLE and GAP. req changes of non-owners during GRANT have no effect.
- Reset asserted mid-grant: en=0 and ptr=0 on the cycle after rst is sampled high. The grant in progress is abandoned with no timeout pulse.
- Invariants:
  - gnt is zero or one-hot, and always equals the decoder output pattern for (sel_a, sel_b, en).
  - en never stays high across an owner change.

Test Plan:
- Reset and single request:
  - Stimulus: rst=1 for 2 cycles, then req=4'b0100 held, HOLD_MAX=4.
  - Required response: 1 cycle later en=1, gnt_id=2, sel_a=1, sel_b=0, gnt=4'b0100.
  - After 4 cycles: timeout=1 for one cycle, en=0.
- done release and rotation:
  - Stimulus: req=4'b1111; done=1 in the 2nd cycle of every grant.
  - Required response: grant sequence gnt_id=0,1,2,3,0.
  - Each grant lasts 2 cycles, and en=0 for exactly 1 cycle between grants.
- Wrap-around:
  - Stimulus: ptr reaches 3 after a grant to 2; then req=4'b1001.
  - Required response: gnt_id=3 first, then 0.
- Request drop:
  - Stimulus: owner 1 drops req[1] after 1 cycle while req[3]=1.
  - Required response: en low 1 cycle, then gnt_id=3; timeout stays 0.
- Simultaneous done and timeout:
  - Stimulus: HOLD_MAX=1, req=4'b0010, done=1 in the grant cycle.
  - Required response: 1-cycle grant with timeout=0.
  - With done=0 instead: timeout=1.
- Reset mid-grant:
  - Stimulus: assert rst during the 2nd cycle of a grant to index 2.
  - Required response: next cycle en=0, gnt=0, timeout=0.
  - After rst deasserts with req=4'b1111: first grant gnt_id=0.
